reel_scroller: RTL and testbench
================================

# reel_scroller

Address generator for the slot-machine reel display, sitting directly upstream of the sprite ROM. It maps VGA raster coordinates to `sprite_idx` / `x_in_sprite` / `y_in_sprite` for the sprite ROM, and runs the per-reel spin/stop state machines that scroll each 7-symbol strip. It also delays the reel-window qualifier so that `pix_en` lines up with the ROM's `pixel_rgb`.

## Interface
- `NUM_REELS`, 3: number of reels.
- `REEL_X0`, 160: left pixel column of reel 0.
- `REEL_PITCH`, 128: column distance between reel origins.
- `REEL_Y0`, 144: top pixel row of the reel window.
- `MAX_SPEED`, 16: spin speed in px/frame; must be 1..64.
- `STOP_SPEED`, 4: landing speed floor in px/frame, 1..`MAX_SPEED`.
- `ROM_LATENCY`, 2: cycles from the ROM address inputs to `pixel_rgb`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `hcount`  in  10  raster column.
- `vcount`  in  10  raster row.
- `frame_tick`  in  1  one-cycle pulse once per frame, during vblank.
- `start`  in  1  spin request, one-cycle pulse.
- `stop_req`  in  `NUM_REELS`  per-reel stop request, level or pulse.
- `sprite_idx`  out  3  symbol index 0..6, to the ROM.
- `x_in_sprite`  out  6  column within the sprite.
- `y_in_sprite`  out  6  row within the sprite.
- `pix_en`  out  1  high when `pixel_rgb` belongs to a reel window.
- `spinning`  out  `NUM_REELS`  reel is not IDLE.
- `all_stopped`  out  1  all reels IDLE.
- `result`  out  3*`NUM_REELS`  middle-row symbol per reel; reel r occupies bits [3r+2:3r].

## Operation
- **Strip layout**
  - Symbol k occupies strip rows 64k..64k+63, for k = 0..6.
  - Strip length is 448 rows.
  - Each reel holds a 9-bit position `pos[r]` in the range 0..447.
- **Window**
  - Reel r covers hcount in [REEL_X0 + r·REEL_PITCH, +64) and vcount in [REEL_Y0, REEL_Y0 + 192).
  - This gives 3 visible symbols per reel.
- **Mapping**
  - s = (vcount − REEL_Y0 + pos[r]) mod 448.
  - `sprite_idx` = s[8:6], `y_in_sprite` = s[5:0].
  - `x_in_sprite` = hcount − reel origin.
  - Outside every window, all three outputs are 0.
  - The modulo is a single conditional subtract of 448; the sum is at most 191 + 447.
- **Per-reel FSM**, states IDLE, SPIN, STOPPING:
  - IDLE → SPIN: `start` while `all_stopped`. Sets speed = `MAX_SPEED`.
  - `start` is ignored unless `all_stopped`.
  - SPIN → STOPPING: `stop_req[r]` is high. It is ignored in all other states.
  - SPIN on `frame_tick`: pos = (pos + speed) mod 448.
  - STOPPING on `frame_tick`: see Configuration. When landing occurs, pos snaps to the next multiple of 64 (448 wraps to 0), speed = 0, and the state returns to IDLE.
  - Landing condition: (pos mod 64) + speed ≥ 64.
- **Result**
  - `result[r]` = ((pos[r] >> 6) + 1) mod 7, which is the middle-row symbol.
  - It is updated whenever the reel enters IDLE.
- **Simultaneous events**
  - `start` and `stop_req` in the same cycle: `start` wins and `stop_req` is dropped.
  - `stop_req` and `frame_tick` in the same cycle: the move uses SPIN rules, then the state becomes STOPPING.
- **Reset**, including mid-spin:
  - All pos = 0, speed = 0, all reels IDLE.
  - Address outputs = 0, `pix_en` pipeline cleared.
  - `spinning` = 0, `all_stopped` = 1, each `result` = 1.

## Timing
- Address outputs are registered: 1 cycle after `hcount`/`vcount`.
- `pix_en` = window hit delayed 1 + `ROM_LATENCY` cycles, aligned with `pixel_rgb`.
- A pos update becomes visible on the cycle after `frame_tick`; positions never change mid-frame.
- `spinning` and `all_stopped` are registered; they update the cycle after the state change.
- `result` is valid from the cycle `all_stopped` rises.

## Configuration
- `REEL_DECEL_EN` defined, STOPPING on `frame_tick`:
  - If speed > `STOP_SPEED`: pos += speed (mod 448), then speed −= 1.
  - Otherwise: apply the landing check. If it fails, pos += speed.
- `REEL_DECEL_EN` undefined:
  - The landing check is applied on every STOPPING `frame_tick` at unchanged speed.

## Test plan
- **Reset mapping:** reset, hcount=170, vcount=214 → next cycle `sprite_idx`=1, `y_in_sprite`=6, `x_in_sprite`=10; `pix_en` high 3 cycles after the stimulus.
- **Window edges:** hcount=223 gives reel 0 hit with x=63; hcount=224 gives no hit, outputs 0, `pix_en` low; hcount=288 gives reel 1 with x=0.
- **Wrap:** `start`, then 26 `frame_tick`s → pos=416; vcount=184 → s=8 gives `sprite_idx`=0, y=8. After 28 ticks, pos=0.
- **Stop, macro off:** `start`, 3 ticks (pos=48), `stop_req[0]`, 1 tick → pos0=64, reel 0 IDLE, `result[2:0]`=2; the other reels keep spinning and `start` is ignored.
- **Stop, macro on:** same stimulus → speed sequence 16, 15, …, 4; the final pos is a multiple of 64; `result` = pos/64 + 1 mod 7.
- **Conflicts:** `start` and `stop_req` in the same cycle → all reels SPIN, none STOPPING. Reset asserted mid-STOPPING → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/reel_scroller.sv
// reel_scroller: raster-to-sprite-ROM address generator and per-reel spin/stop
// sequencing for the slot-machine reel display.
//
// Optional feature macro: REEL_DECEL_EN
//   defined   - a stopping reel decelerates by 1 px/frame down to STOP_SPEED,
//               then lands on the next symbol boundary it reaches.
//   undefined - a stopping reel keeps its spin speed and lands on the next
//               symbol boundary it reaches.
//
// Per-reel states:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | reel parked on a symbol boundary, speed 0, result valid
//   ST_SPIN     | reel scrolling at speed px per frame_tick
//   ST_STOPPING | stop requested; scrolling until the next boundary is reached
module reel_scroller #(
    parameter int NUM_REELS   = 3,
    parameter int REEL_X0     = 160,
    parameter int REEL_PITCH  = 128,
    parameter int REEL_Y0     = 144,
    parameter int MAX_SPEED   = 16,
    parameter int STOP_SPEED  = 4,
    parameter int ROM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic [NUM_REELS-1:0]   stop_req,
    output logic [2:0]             sprite_idx,
    output logic [5:0]             x_in_sprite,
    output logic [5:0]             y_in_sprite,
    output logic                   pix_en,
    output logic [NUM_REELS-1:0]   spinning,
    output logic                   all_stopped,
    output logic [3*NUM_REELS-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPIN     = 2'd1,
        ST_STOPPING = 2'd2
    } reel_state_t;

    localparam logic [6:0] MAX_SPD = 7'(MAX_SPEED);
`ifdef REEL_DECEL_EN
    localparam logic [6:0] STOP_SPD = 7'(STOP_SPEED);
`endif

    // Reject parameter sets the datapath widths cannot represent.
    if (MAX_SPEED < 1 || MAX_SPEED > 64) begin : g_bad_max_speed
        $error("reel_scroller: MAX_SPEED must be 1..64");
    end
    if (STOP_SPEED < 1 || STOP_SPEED > MAX_SPEED) begin : g_bad_stop_speed
        $error("reel_scroller: STOP_SPEED must be 1..MAX_SPEED");
    end
    if (ROM_LATENCY < 1) begin : g_bad_rom_latency
        $error("reel_scroller: ROM_LATENCY must be at least 1");
    end

    reel_state_t state_q  [NUM_REELS];
    reel_state_t state_d  [NUM_REELS];
    logic [8:0]  pos_q    [NUM_REELS];
    logic [8:0]  pos_d    [NUM_REELS];
    logic [6:0]  speed_q  [NUM_REELS];
    logic [6:0]  speed_d  [NUM_REELS];
    logic [2:0]  result_q [NUM_REELS];
    logic [2:0]  result_d [NUM_REELS];

    logic                 start_acc;
    logic [NUM_REELS-1:0] busy_c;

    // Position advance around the 448-row strip; the sum never reaches 896,
    // so one conditional subtract is enough.
    function automatic logic [8:0] wrap_add(input logic [8:0] p, input logic [6:0] s);
        logic [9:0] t;
        t = {1'b0, p} + {3'b000, s};
        if (t >= 10'd448) begin
            t = t - 10'd448;
        end
        return t[8:0];
    endfunction

    function automatic logic [2:0] next_sym(input logic [2:0] k);
        return (k >= 3'd6) ? 3'd0 : k + 3'd1;
    endfunction

    // True when this frame's move would reach or cross a symbol boundary.
    function automatic logic lands(input logic [8:0] p, input logic [6:0] s);
        return ({2'b00, p[5:0]} + {1'b0, s}) >= 8'd64;
    endfunction

    // ---------------------------------------------------------------
    // Raster mapping
    // ---------------------------------------------------------------
    logic [10:0]          dy_full;
    logic                 row_hit;
    logic [NUM_REELS-1:0] reel_hit;
    logic [5:0]           reel_x [NUM_REELS];
    logic [8:0]           reel_s [NUM_REELS];

    assign dy_full = {1'b0, vcount} - 11'(REEL_Y0);
    assign row_hit = ({1'b0, vcount} >= 11'(REEL_Y0)) && (dy_full < 11'd192);

    for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel_map
        localparam logic [10:0] ORG = 11'(REEL_X0 + g * REEL_PITCH);
        logic [10:0] dx;
        logic [9:0]  sum;

        assign dx          = {1'b0, hcount} - ORG;
        assign reel_hit[g] = row_hit && ({1'b0, hcount} >= ORG) && (dx < 11'd64);
        assign reel_x[g]   = dx[5:0];
        assign sum         = {2'b00, dy_full[7:0]} + {1'b0, pos_q[g]};
        assign reel_s[g]   = (sum >= 10'd448) ? 9'(sum - 10'd448) : sum[8:0];
        assign result[3*g +: 3] = result_q[g];
    end

    logic       addr_hit;
    logic [2:0] idx_c;
    logic [5:0] x_c;
    logic [5:0] y_c;

    // Select the reel window the beam is in; everything is zero outside all windows.
    always_comb begin
        addr_hit = 1'b0;
        idx_c    = 3'd0;
        x_c      = 6'd0;
        y_c      = 6'd0;
        for (int r = 0; r < NUM_REELS; r++) begin
            if (reel_hit[r]) begin
                addr_hit = 1'b1;
                idx_c    = reel_s[r][8:6];
                x_c      = reel_x[r];
                y_c      = reel_s[r][5:0];
            end
        end
    end

    logic [ROM_LATENCY:0] pix_pipe;

    // Registered ROM address plus the window qualifier delayed to match pixel_rgb.
    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_idx  <= 3'd0;
            x_in_sprite <= 6'd0;
            y_in_sprite <= 6'd0;
            pix_pipe    <= '0;
        end else begin
            sprite_idx  <= idx_c;
            x_in_sprite <= x_c;
            y_in_sprite <= y_c;
            pix_pipe    <= {pix_pipe[ROM_LATENCY-1:0], addr_hit};
        end
    end

    assign pix_en = pix_pipe[ROM_LATENCY];

    // ---------------------------------------------------------------
    // Reel state machines
    // ---------------------------------------------------------------

    // Next state, position, speed and latched result for every reel.
    always_comb begin
        start_acc = start && all_stopped;
        for (int r = 0; r < NUM_REELS; r++) begin
            state_d[r]  = state_q[r];
            pos_d[r]    = pos_q[r];
            speed_d[r]  = speed_q[r];
            result_d[r] = result_q[r];
            busy_c[r]   = (state_q[r] != ST_IDLE);
            case (state_q[r])
                ST_IDLE: begin
                    if (start_acc) begin
                        state_d[r] = ST_SPIN;
                        speed_d[r] = MAX_SPD;
                    end
                end
                ST_SPIN: begin
                    if (frame_tick) begin
                        pos_d[r] = wrap_add(pos_q[r], speed_q[r]);
                    end
                    if (stop_req[r] && !start_acc) begin
                        state_d[r] = ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (frame_tick) begin
`ifdef REEL_DECEL_EN
                        if (speed_q[r] > STOP_SPD) begin
                            pos_d[r]   = wrap_add(pos_q[r], speed_q[r]);
                            speed_d[r] = speed_q[r] - 7'd1;
                        end else
`endif
                        if (lands(pos_q[r], speed_q[r])) begin
                            pos_d[r]    = {next_sym(pos_q[r][8:6]), 6'd0};
                            speed_d[r]  = 7'd0;
                            state_d[r]  = ST_IDLE;
                            result_d[r] = next_sym(next_sym(pos_q[r][8:6]));
                        end else begin
                            pos_d[r] = wrap_add(pos_q[r], speed_q[r]);
                        end
                    end
                end
                default: begin
                    state_d[r] = ST_IDLE;
                    speed_d[r] = 7'd0;
                end
            endcase
        end
    end

    // Reel state registers; reset parks every reel on symbol 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REELS; r++) begin
                state_q[r]  <= ST_IDLE;
                pos_q[r]    <= 9'd0;
                speed_q[r]  <= 7'd0;
                result_q[r] <= 3'd1;
            end
        end else begin
            for (int r = 0; r < NUM_REELS; r++) begin
                state_q[r]  <= state_d[r];
                pos_q[r]    <= pos_d[r];
                speed_q[r]  <= speed_d[r];
                result_q[r] <= result_d[r];
            end
        end
    end

    // Status flags follow the state registers by one cycle, so result is settled
    // by the time all_stopped rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            spinning    <= '0;
            all_stopped <= 1'b1;
        end else begin
            spinning    <= busy_c;
            all_stopped <= ~|busy_c;
        end
    end

endmodule

// File: tb/tb_reel_scroller.sv
// Directed bench for reel_scroller: stimulus queues hand-computed expectations
// with a due cycle; a monitor compares them against the DUT outputs.
module tb_reel_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       frame_tick;
    logic       start;
    logic [2:0] stop_req;
    logic [2:0] sprite_idx;
    logic [5:0] x_in_sprite;
    logic [5:0] y_in_sprite;
    logic       pix_en;
    logic [2:0] spinning;
    logic       all_stopped;
    logic [8:0] result;

    always #5 clk = ~clk;

    reel_scroller dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .frame_tick  (frame_tick),
        .start       (start),
        .stop_req    (stop_req),
        .sprite_idx  (sprite_idx),
        .x_in_sprite (x_in_sprite),
        .y_in_sprite (y_in_sprite),
        .pix_en      (pix_en),
        .spinning    (spinning),
        .all_stopped (all_stopped),
        .result      (result)
    );

    // Observation word: idx[28:26] x[25:20] y[19:14] pix[13] spin[12:10] all[9] result[8:0]
    logic [28:0] obs;
    assign obs = {sprite_idx, x_in_sprite, y_in_sprite, pix_en, spinning, all_stopped, result};

    localparam logic [28:0] M_ADDR = {15'h7FFF, 14'h0};
    localparam logic [28:0] M_PIX  = 29'h0000_2000;
    localparam logic [28:0] M_SPIN = 29'h0000_1C00;
    localparam logic [28:0] M_ALL  = 29'h0000_0200;
    localparam logic [28:0] M_RES  = 29'h0000_01FF;
    localparam logic [28:0] M_FULL = 29'h1FFF_FFFF;

    function automatic logic [28:0] f_addr(input logic [2:0] i, input logic [5:0] x, input logic [5:0] y);
        return {i, x, y, 14'd0};
    endfunction
    function automatic logic [28:0] f_pix(input logic b);
        return {15'd0, b, 13'd0};
    endfunction
    function automatic logic [28:0] f_spin(input logic [2:0] s);
        return {16'd0, s, 10'd0};
    endfunction
    function automatic logic [28:0] f_all(input logic b);
        return {19'd0, b, 9'd0};
    endfunction
    function automatic logic [28:0] f_res(input logic [8:0] r);
        return {20'd0, r};
    endfunction

    typedef struct {
        int          due;
        string       name;
        logic [28:0] exp;
        logic [28:0] mask;
    } chk_t;

    chk_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due on this cycle.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int i;
                i = 0;
                while (i < sb.size()) begin
                    if (sb[i].due <= cyc) begin
                        n_cmp++;
                        if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                            n_bad++;
                            $display("FAIL %s: cycle %0d got %h required %h", sb[i].name, cyc,
                                     obs & sb[i].mask, sb[i].exp & sb[i].mask);
                        end
                        sb.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end
    end

    task automatic chk_at(input int d, input string nm, input logic [28:0] e, input logic [28:0] m);
        chk_t c;
        c.due  = cyc + d;
        c.name = nm;
        c.exp  = e;
        c.mask = m;
        sb.push_back(c);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            step(); frame_tick = 1'b1;
            step(); frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        step(); reset = 1'b1;
        step(); reset = 1'b0;
    endtask

    task automatic pulse_start();
        step(); start = 1'b1;
        step(); start = 1'b0;
    endtask

    task automatic map_chk(input logic [9:0] h, input logic [9:0] v, input string nm,
                           input logic [2:0] i, input logic [5:0] x, input logic [5:0] y);
        step(); hcount = h; vcount = v;
        chk_at(1, nm, f_addr(i, x, y), M_ADDR);
        step(); hcount = 10'd0; vcount = 10'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hcount = 10'd0; vcount = 10'd0;
        frame_tick = 1'b0; start = 1'b0; stop_req = 3'b000;
        step(); step();
        chk_at(1, "rst_state", f_res(9'o111) | f_all(1'b1), M_FULL);
        step(); reset = 1'b0;

        // Mapping with all reels at pos 0, plus pix_en latency
        step(); hcount = 10'd170; vcount = 10'd214;
        chk_at(1, "map_r0", f_addr(3'd1, 6'd10, 6'd6), M_ADDR);
        chk_at(2, "pix_early", f_pix(1'b0), M_PIX);
        chk_at(3, "pix_lat", f_pix(1'b1), M_PIX);
        step(); hcount = 10'd0; vcount = 10'd0;
        chk_at(3, "pix_off", f_pix(1'b0), M_PIX);

        // Window edges on consecutive cycles
        step(); hcount = 10'd223; vcount = 10'd214;
        chk_at(1, "r0_right", f_addr(3'd1, 6'd63, 6'd6), M_ADDR);
        chk_at(3, "pix_r0_right", f_pix(1'b1), M_PIX);
        step(); hcount = 10'd224;
        chk_at(1, "gap_224", 29'd0, M_ADDR);
        chk_at(3, "pix_gap_224", f_pix(1'b0), M_PIX);
        step(); hcount = 10'd288;
        chk_at(1, "r1_left", f_addr(3'd1, 6'd0, 6'd6), M_ADDR);
        chk_at(3, "pix_r1_left", f_pix(1'b1), M_PIX);
        step(); hcount = 10'd159;
        chk_at(1, "left_159", 29'd0, M_ADDR);
        chk_at(3, "pix_left_159", f_pix(1'b0), M_PIX);
        step(); hcount = 10'd170; vcount = 10'd335;
        chk_at(1, "bottom_row", f_addr(3'd2, 6'd10, 6'd63), M_ADDR);
        step(); vcount = 10'd336;
        chk_at(1, "below_win", 29'd0, M_ADDR);
        chk_at(3, "pix_below", f_pix(1'b0), M_PIX);
        step(); vcount = 10'd143;
        chk_at(1, "above_win", 29'd0, M_ADDR);
        step(); hcount = 10'd479; vcount = 10'd144;
        chk_at(1, "r2_corner", f_addr(3'd0, 6'd63, 6'd0), M_ADDR);
        chk_at(3, "pix_r2_corner", f_pix(1'b1), M_PIX);
        step(); hcount = 10'd0; vcount = 10'd0;
        repeat (4) step();

        // Wrap: 26 ticks at 16 px -> pos 416, 28 ticks -> pos 0
        step(); start = 1'b1;
        chk_at(2, "spin_all", f_spin(3'b111) | f_all(1'b0), M_SPIN | M_ALL);
        step(); start = 1'b0;
        tick(26);
        map_chk(10'd170, 10'd184, "wrap_r0", 3'd0, 6'd10, 6'd8);
        map_chk(10'd300, 10'd184, "wrap_r1", 3'd0, 6'd12, 6'd8);
        tick(2);
        map_chk(10'd170, 10'd184, "wrap_zero", 3'd0, 6'd10, 6'd40);
        do_reset();

        // Stop reel 0 after 3 ticks (pos 48)
        pulse_start();
        tick(3);
        step(); stop_req = 3'b001;
        step(); stop_req = 3'b000;
`ifndef REEL_DECEL_EN
        tick(1);
        step(); step();
        chk_at(1, "stop_flags", f_spin(3'b110) | f_all(1'b0) | f_res(9'o112), M_SPIN | M_ALL | M_RES);
        tick(1);
        map_chk(10'd160, 10'd144, "r0_parked", 3'd1, 6'd0, 6'd0);
        map_chk(10'd288, 10'd144, "r1_moving", 3'd1, 6'd0, 6'd16);
        pulse_start();
        step(); step();
        chk_at(1, "start_ignored", f_spin(3'b110), M_SPIN);
        tick(1);
        map_chk(10'd160, 10'd144, "r0_still", 3'd1, 6'd0, 6'd0);
        map_chk(10'd288, 10'd144, "r1_96", 3'd1, 6'd0, 6'd32);
        step(); stop_req = 3'b110;
        step(); stop_req = 3'b000;
        tick(1);
        step(); frame_tick = 1'b1;
        chk_at(2, "all_stop_rise", f_spin(3'b000) | f_all(1'b1) | f_res(9'o332), M_SPIN | M_ALL | M_RES);
        step(); frame_tick = 1'b0;
        map_chk(10'd288, 10'd144, "r1_landed", 3'd2, 6'd0, 6'd0);
        pulse_start();
        step();
        chk_at(1, "restart_ok", f_spin(3'b111), M_SPIN);
`else
        tick(16);
        step(); step();
        chk_at(1, "decel_not_yet", f_spin(3'b111), M_SPIN);
        tick(1);
        step(); step();
        chk_at(1, "decel_landed", f_spin(3'b110) | f_res(9'o114), M_SPIN | M_RES);
        map_chk(10'd160, 10'd144, "decel_r0_pos", 3'd3, 6'd0, 6'd0);
        map_chk(10'd288, 10'd144, "decel_r1_pos", 3'd5, 6'd0, 6'd0);
`endif
        do_reset();

        // Conflicts: start with stop_req wins; then stop_req coinciding with a tick
        step(); start = 1'b1; stop_req = 3'b111;
        step(); start = 1'b0; stop_req = 3'b000;
        tick(4);
        step(); step();
        chk_at(1, "conflict_spin", f_spin(3'b111), M_SPIN);
        map_chk(10'd160, 10'd144, "conflict_pos", 3'd1, 6'd0, 6'd0);
        step(); frame_tick = 1'b1; stop_req = 3'b100;
        step(); frame_tick = 1'b0; stop_req = 3'b000;
        map_chk(10'd416, 10'd144, "stop_tick_r2", 3'd1, 6'd0, 6'd16);
        step(); hcount = 10'd288; vcount = 10'd144;
        step(); reset = 1'b1; hcount = 10'd170; vcount = 10'd214;
        chk_at(1, "rst_mid_stop", f_res(9'o111) | f_all(1'b1), M_FULL);
        step(); reset = 1'b0;
        chk_at(1, "post_rst_map", f_addr(3'd1, 6'd10, 6'd6), M_ADDR);
        chk_at(3, "post_rst_pix", f_pix(1'b1), M_PIX);
        step(); hcount = 10'd0; vcount = 10'd0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        step();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d checks still pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
